// File: rtl/frame_rd_stream_if.sv
// rtl/frame_rd_stream_if.sv - memory read port and pixel stream bundle for frame_rd_stream
//
// Signals:
//   rd_en, rd_addr            request to the ram_int_4p read port
//   rd_rdy                    memory port accepts a request this cycle
//   rd_data, rd_data_valid    returned word, in request order
//   pix_data, pix_valid       pixel stream towards the display pipeline
//   pix_ready                 downstream accepts the current pixel
//   pix_sof, pix_eof          first / last pixel of the frame
// Modports:
//   master  frame_rd_stream side
//   slave   memory port + downstream side
interface frame_rd_stream_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic [23:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eof;

  modport master (
    output rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eof,
    input  rd_rdy, rd_data, rd_data_valid, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eof,
    output rd_rdy, rd_data, rd_data_valid, pix_ready
  );
endinterface

// File: rtl/frame_rd_stream.sv
// rtl/frame_rd_stream.sv - fetches one frame from a ram_int_4p read port as a pixel stream
//
// Optional feature macro: FRAME_RD_PATT_CHK_EN (adds CHK_PATT, chk_fail, chk_cnt).
//
// Ports:
//   clk        system clock (clk_33m domain)
//   reset      synchronous, active-low reset
//   start      one-cycle pulse, begins a frame fetch when idle
//   base_addr  first word address, sampled on accepted start
//   busy       high from accepted start until done
//   done       one-cycle pulse after the last pixel is accepted downstream
//   chk_fail   (feature) sticky pattern mismatch flag
//   chk_cnt    (feature) accepted returns in the current frame, saturating
//   bus        frame_rd_stream_if.master: memory read port + pixel stream
module frame_rd_stream #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int FRAME_WORDS = 5,
  parameter int FIFO_DEPTH  = 8
`ifdef FRAME_RD_PATT_CHK_EN
  ,
  parameter logic [23:0] CHK_PATT = 24'hFFFFFF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
`ifdef FRAME_RD_PATT_CHK_EN
  output logic              chk_fail,
  output logic [15:0]       chk_cnt,
`endif
  frame_rd_stream_if.master bus
);

  localparam int FCW = $clog2(FRAME_WORDS + 1);
  localparam int QCW = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  localparam logic [FCW-1:0] FW_L    = FCW'(FRAME_WORDS);
  localparam logic [FCW-1:0] FW_M1   = FCW'(FRAME_WORDS - 1);
  localparam logic [QCW:0]   DEPTH_L = (QCW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [FCW-1:0]    issued;
  logic [FCW-1:0]    popped;
  logic [QCW-1:0]    outstanding;
  logic [QCW-1:0]    fifo_count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [23:0]       fifo_mem [FIFO_DEPTH];

  logic [QCW:0] credit_used;
  logic         start_ok;
  logic         accept;
  logic         ret;
  logic         pop;

  // Every entry already in the FIFO or still owed by memory holds a credit,
  // so a request is only issued when its return is guaranteed a slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign start_ok    = (state == ST_IDLE) && start;

  assign bus.rd_en   = (state == ST_FETCH) && (issued < FW_L) && (credit_used < DEPTH_L);
  assign bus.rd_addr = addr_q;
  assign accept      = bus.rd_en && bus.rd_rdy;

  // Returns are only meaningful while a frame is in flight and something is owed;
  // stragglers from a frame aborted by reset fall through here.
  assign ret = bus.rd_data_valid && ((state == ST_FETCH) || (state == ST_DRAIN))
               && (outstanding != '0);

  assign bus.pix_valid = (fifo_count != '0);
  assign bus.pix_data  = fifo_mem[rd_ptr];
  assign bus.pix_sof   = bus.pix_valid && (popped == '0);
  assign bus.pix_eof   = bus.pix_valid && (popped == FW_M1);
  assign pop           = bus.pix_valid && bus.pix_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (accept && (issued == FW_M1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave on the edge that pops the last pixel so done follows it directly.
        if ((popped == FW_L) || (pop && (popped == FW_M1))) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q      <= '0;
      issued      <= '0;
      popped      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (start_ok) begin
      addr_q      <= base_addr;
      issued      <= '0;
      popped      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr_q + ADDR_W'(1);
        issued <= issued + FCW'(1);
      end
      outstanding <= outstanding + QCW'(accept) - QCW'(ret);
      if (ret) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        popped <= popped + FCW'(1);
      end
      fifo_count <= fifo_count + QCW'(ret) - QCW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (ret) fifo_mem[wr_ptr] <= bus.rd_data[23:0];
  end

  generate
    if (DATA_W > 24) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^bus.rd_data[DATA_W-1:24];
    end
  endgenerate

`ifdef FRAME_RD_PATT_CHK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_fail <= 1'b0;
      chk_cnt  <= '0;
    end else if (start_ok) begin
      chk_fail <= 1'b0;
      chk_cnt  <= '0;
    end else if (ret) begin
      if (bus.rd_data[23:0] != CHK_PATT) chk_fail <= 1'b1;
      if (chk_cnt != 16'hFFFF) chk_cnt <= chk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_rd_stream.sv
// tb/tb_frame_rd_stream.sv - directed self-checking bench for frame_rd_stream
module tb_frame_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start     [4];
  logic [23:0] base_addr [4];
  logic        busy_o    [4];
  logic        done_o    [4];
  logic        rd_rdy    [4];
  logic        pix_ready [4];
  logic        rd_en_o   [4];
  logic [23:0] rd_addr_o [4];
  logic [23:0] pix_data_o[4];
  logic        pix_valid_o[4];
  logic        sof_o     [4];
  logic        eof_o     [4];
`ifdef FRAME_RD_PATT_CHK_EN
  logic        chk_fail_o[4];
  logic [15:0] chk_cnt_o [4];
`endif

  logic        patt_mode = 1'b0;
  logic        bad_en    = 1'b0;
  logic [23:0] bad_addr  = 24'h0;

  // Instances: 0 = 5 words/depth 8, 1 = 16 words/depth 4, 2 = 3 words, 3 = 1 word/depth 2
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int FW = (g == 0) ? 5 : (g == 1) ? 16 : (g == 2) ? 3 : 1;
      localparam int FD = (g == 1) ? 4 : (g == 3) ? 2 : 8;

      frame_rd_stream_if #(.ADDR_W(24), .DATA_W(32)) bus ();

      // Memory model: each accepted request returns its word 3 clocks later.
      logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
      logic [23:0] a1 = '0, a2 = '0, a3 = '0;
      always @(posedge clk) begin
        v1 <= bus.rd_en && bus.rd_rdy;
        a1 <= bus.rd_addr;
        v2 <= v1;
        a2 <= a1;
        v3 <= v2;
        a3 <= a2;
      end
      assign bus.rd_data_valid = v3;
      assign bus.rd_data = {8'hA5, patt_mode ? ((bad_en && a3 == bad_addr) ? 24'h00FFFF : 24'hFFFFFF)
                                             : (a3 ^ 24'h3C3C3C)};
      assign bus.rd_rdy    = rd_rdy[g];
      assign bus.pix_ready = pix_ready[g];
      assign rd_en_o[g]     = bus.rd_en;
      assign rd_addr_o[g]   = bus.rd_addr;
      assign pix_data_o[g]  = bus.pix_data;
      assign pix_valid_o[g] = bus.pix_valid;
      assign sof_o[g]       = bus.pix_sof;
      assign eof_o[g]       = bus.pix_eof;

      frame_rd_stream #(
        .ADDR_W(24), .DATA_W(32), .FRAME_WORDS(FW), .FIFO_DEPTH(FD)
      ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start[g]),
        .base_addr(base_addr[g]),
        .busy     (busy_o[g]),
        .done     (done_o[g]),
`ifdef FRAME_RD_PATT_CHK_EN
        .chk_fail (chk_fail_o[g]),
        .chk_cnt  (chk_cnt_o[g]),
`endif
        .bus      (bus)
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  logic [23:0] got_addr[$];
  logic [23:0] got_pix[$];
  bit          got_sof[$];
  bit          got_eof[$];
  int done_cnt, done_c, last_pop_c, hold_viol, req_at_bp_end, busy_at_1;
  bit timed_out;
  int rdy_lo_a = -1, rdy_lo_b = -1, prdy_lo_a = -1, prdy_lo_b = -1;

  // Drives one frame on instance i and records what the DUT produced.
  task automatic run_frame(input int i, input logic [23:0] base, input int max_c);
    bit          pend = 0;
    logic [23:0] pend_addr = '0;
    got_addr.delete(); got_pix.delete(); got_sof.delete(); got_eof.delete();
    done_cnt = 0; done_c = -10; last_pop_c = -10; hold_viol = 0;
    req_at_bp_end = -1; busy_at_1 = -1;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      start[i]     = (c == 0);
      base_addr[i] = base;
      rd_rdy[i]    = !(c >= rdy_lo_a && c <= rdy_lo_b);
      pix_ready[i] = !(c >= prdy_lo_a && c <= prdy_lo_b);
      if (pend && (!rd_en_o[i] || rd_addr_o[i] != pend_addr)) hold_viol++;
      pend      = rd_en_o[i] && !rd_rdy[i];
      pend_addr = rd_addr_o[i];
      if (c == 1) busy_at_1 = int'(busy_o[i]);
      if (rd_en_o[i] && rd_rdy[i]) got_addr.push_back(rd_addr_o[i]);
      if (c == prdy_lo_b) req_at_bp_end = got_addr.size();
      if (pix_valid_o[i] && pix_ready[i]) begin
        got_pix.push_back(pix_data_o[i]);
        got_sof.push_back(sof_o[i]);
        got_eof.push_back(eof_o[i]);
        last_pop_c = c;
      end
      if (done_o[i]) begin
        done_cnt++;
        done_c = c;
      end
      if (done_cnt > 0 && c == done_c + 1) break;
    end
    timed_out = (done_cnt == 0);
    start[i] = 1'b0; rd_rdy[i] = 1'b1; pix_ready[i] = 1'b1;
    rdy_lo_a = -1; rdy_lo_b = -1; prdy_lo_a = -1; prdy_lo_b = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0; base_addr[i] = '0; rd_rdy[i] = 1'b1; pix_ready[i] = 1'b1;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_en_o[i], busy_o[i], done_o[i], pix_valid_o[i], sof_o[i], eof_o[i]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags[%0d] got %b exp 000000", i,
                 {rd_en_o[i], busy_o[i], done_o[i], pix_valid_o[i], sof_o[i], eof_o[i]});
      end
      checks++;
      if (rd_addr_o[i] !== 24'h0) begin
        errors++; $display("FAIL reset_rd_addr[%0d] got %h exp 000000", i, rd_addr_o[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(0, 24'h000000, 60);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (got_addr.size() !== 5) begin errors++; $display("FAIL basic_req_count got %0d exp 5", got_addr.size()); end
    for (int k = 0; k < got_addr.size() && k < 5; k++) begin
      checks++;
      if (got_addr[k] !== 24'(k)) begin errors++; $display("FAIL basic_addr[%0d] got %h exp %h", k, got_addr[k], 24'(k)); end
    end
    checks++; if (got_pix.size() !== 5) begin errors++; $display("FAIL basic_pix_count got %0d exp 5", got_pix.size()); end
    for (int k = 0; k < got_pix.size() && k < 5; k++) begin
      logic [25:0] exp_v, got_v;
      exp_v = {24'(k) ^ 24'h3C3C3C, k == 0, k == 4};
      got_v = {got_pix[k], got_sof[k], got_eof[k]};
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL basic_pix[%0d] got %h exp %h", k, got_v, exp_v); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_c !== last_pop_c + 1) begin errors++; $display("FAIL basic_done_cycle got %0d exp %0d", done_c, last_pop_c + 1); end
    checks++; if (busy_at_1 !== 1) begin errors++; $display("FAIL basic_busy_start got %0d exp 1", busy_at_1); end
    checks++; if ({busy_o[0], done_o[0]} !== 2'b00) begin errors++; $display("FAIL basic_after_done got %b exp 00", {busy_o[0], done_o[0]}); end
  endtask

  task automatic test_rd_stall();
    rdy_lo_a = 3; rdy_lo_b = 12;
    run_frame(0, 24'h000200, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", hold_viol); end
    checks++; if (got_addr.size() !== 5) begin errors++; $display("FAIL stall_req_count got %0d exp 5", got_addr.size()); end
    for (int k = 0; k < got_addr.size() && k < 5; k++) begin
      checks++;
      if (got_addr[k] !== 24'h000200 + 24'(k)) begin errors++; $display("FAIL stall_addr[%0d] got %h exp %h", k, got_addr[k], 24'h000200 + 24'(k)); end
    end
    for (int k = 0; k < got_pix.size() && k < 5; k++) begin
      checks++;
      if (got_pix[k] !== ((24'h000200 + 24'(k)) ^ 24'h3C3C3C)) begin
        errors++; $display("FAIL stall_pix[%0d] got %h exp %h", k, got_pix[k], (24'h000200 + 24'(k)) ^ 24'h3C3C3C);
      end
    end
  endtask

  task automatic test_back_pressure();
    prdy_lo_a = 0; prdy_lo_b = 40;
    run_frame(1, 24'h000100, 300);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++; if (req_at_bp_end !== 4) begin errors++; $display("FAIL bp_req_while_blocked got %0d exp 4", req_at_bp_end); end
    checks++; if (got_addr.size() !== 16) begin errors++; $display("FAIL bp_req_count got %0d exp 16", got_addr.size()); end
    checks++; if (got_pix.size() !== 16) begin errors++; $display("FAIL bp_pix_count got %0d exp 16", got_pix.size()); end
    for (int k = 0; k < got_pix.size() && k < 16; k++) begin
      logic [25:0] exp_v, got_v;
      exp_v = {(24'h000100 + 24'(k)) ^ 24'h3C3C3C, k == 0, k == 15};
      got_v = {got_pix[k], got_sof[k], got_eof[k]};
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL bp_pix[%0d] got %h exp %h", k, got_v, exp_v); end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_a [3];
    exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    run_frame(2, 24'hFFFFFE, 60);
    checks++; if (got_addr.size() !== 3) begin errors++; $display("FAIL wrap_req_count got %0d exp 3", got_addr.size()); end
    for (int k = 0; k < got_addr.size() && k < 3; k++) begin
      checks++;
      if (got_addr[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", k, got_addr[k], exp_a[k]); end
    end
    for (int k = 0; k < got_pix.size() && k < 3; k++) begin
      checks++;
      if (got_pix[k] !== (exp_a[k] ^ 24'h3C3C3C)) begin errors++; $display("FAIL wrap_pix[%0d] got %h exp %h", k, got_pix[k], exp_a[k] ^ 24'h3C3C3C); end
    end
  endtask

  task automatic test_single_word();
    run_frame(3, 24'h000055, 40);
    checks++; if (got_pix.size() !== 1) begin errors++; $display("FAIL single_pix_count got %0d exp 1", got_pix.size()); end
    if (got_pix.size() > 0) begin
      checks++;
      if ({got_pix[0], got_sof[0], got_eof[0]} !== {24'h000055 ^ 24'h3C3C3C, 2'b11}) begin
        errors++; $display("FAIL single_pix got %h exp %h", {got_pix[0], got_sof[0], got_eof[0]}, {24'h000055 ^ 24'h3C3C3C, 2'b11});
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_cnt got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad_cyc = 0;
    @(negedge clk);
    start[0] = 1'b1; base_addr[0] = 24'h000300; rd_rdy[0] = 1'b1; pix_ready[0] = 1'b1;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (rd_en_o[0] && rd_rdy[0]) n++;
    end
    @(negedge clk);
    rd_rdy[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if ({rd_en_o[0], busy_o[0], done_o[0], pix_valid_o[0], sof_o[0], eof_o[0]} !== 6'b0 || rd_addr_o[0] !== 24'h0) bad_cyc++;
      @(negedge clk);
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL rstmid_reqs_before got %0d exp 2", n); end
    checks++; if (bad_cyc !== 0) begin errors++; $display("FAIL rstmid_idle_outputs got %0d bad cycles exp 0", bad_cyc); end
    rd_rdy[0] = 1'b1;
    run_frame(0, 24'h000400, 60);
    checks++; if (got_addr.size() !== 5 || got_pix.size() !== 5) begin
      errors++; $display("FAIL rstmid_next_counts got %0d/%0d exp 5/5", got_addr.size(), got_pix.size());
    end
    for (int k = 0; k < got_pix.size() && k < 5; k++) begin
      checks++;
      if (got_pix[k] !== ((24'h000400 + 24'(k)) ^ 24'h3C3C3C)) begin
        errors++; $display("FAIL rstmid_pix[%0d] got %h exp %h", k, got_pix[k], (24'h000400 + 24'(k)) ^ 24'h3C3C3C);
      end
    end
  endtask

`ifdef FRAME_RD_PATT_CHK_EN
  task automatic test_patt_chk();
    patt_mode = 1'b1; bad_en = 1'b0;
    run_frame(0, 24'h000500, 60);
    checks++; if ({chk_fail_o[0], chk_cnt_o[0]} !== {1'b0, 16'd5}) begin
      errors++; $display("FAIL chk_good got fail=%b cnt=%0d exp fail=0 cnt=5", chk_fail_o[0], chk_cnt_o[0]);
    end
    bad_en = 1'b1; bad_addr = 24'h000602;
    run_frame(0, 24'h000600, 60);
    checks++; if ({chk_fail_o[0], chk_cnt_o[0]} !== {1'b1, 16'd5}) begin
      errors++; $display("FAIL chk_bad got fail=%b cnt=%0d exp fail=1 cnt=5", chk_fail_o[0], chk_cnt_o[0]);
    end
    repeat (3) @(negedge clk);
    checks++; if (chk_fail_o[0] !== 1'b1) begin errors++; $display("FAIL chk_sticky got %b exp 1", chk_fail_o[0]); end
    bad_en = 1'b0;
    run_frame(0, 24'h000700, 60);
    checks++; if (chk_fail_o[0] !== 1'b0) begin errors++; $display("FAIL chk_clear_on_start got %b exp 0", chk_fail_o[0]); end
    patt_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rd_stall();
    test_back_pressure();
    test_wrap();
    test_single_word();
    test_reset_mid();
`ifdef FRAME_RD_PATT_CHK_EN
    test_patt_chk();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_rd_stream.md
Name: frame_rd_stream

Overview:
- Read-side counterpart of the frame buffer write path: fetches one frame of pixel words from a ram_int_4p read port and delivers them as a valid/ready pixel stream.
- Issues read requests with a credit scheme and buffers returned data in an internal FIFO, so downstream back-pressure never overflows.
- Sits between a ram_int_4p read port (rd_addrN/rd_enN/rd_rdyN/rd_dataN/rd_data_validN) and the display/processing pipeline, in the clk domain.

Parameters:
- ADDR_W, 24, read address width.
- DATA_W, 32, memory word width; pixel is bits [23:0].
- FRAME_WORDS, 5, words per frame (>=1).
- FIFO_DEPTH, 8, return-data FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  system clock (clk_33m domain).
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame fetch when idle.
- base_addr  in  ADDR_W  first word address; sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last pixel is accepted downstream.
- rd_en  out  1  read request to memory port.
- rd_addr  out  ADDR_W  read address; valid while rd_en=1.
- rd_rdy  in  1  memory port can accept a request this cycle.
- rd_data  in  DATA_W  returned word.
- rd_data_valid  in  1  rd_data valid; returns are in request order.
- pix_data  out  24  pixel, from FIFO head rd_data[23:0].
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_sof  out  1  high with first pixel of frame.
- pix_eof  out  1  high with last pixel of frame.

Behaviour:
- Reset (reset=0 at posedge): state IDLE; rd_en, busy, done, pix_valid, pix_sof, pix_eof = 0; rd_addr = 0; FIFO empty; all counters 0. Reset mid-frame discards all in-flight data. rd_data_valid arriving after reset is ignored until the next start.
- Request accepted when rd_en && rd_rdy. rd_addr increments by 1 on each acceptance. rd_en/rd_addr hold stable until accepted.
- Credit rule: rd_en=1 only if issued < FRAME_WORDS and (fifo_count + outstanding) < FIFO_DEPTH. outstanding = accepted requests minus returns. The FIFO can never overflow. No rd_data_valid is dropped.
- FIFO write occurs on rd_data_valid. Pop occurs on pix_valid && pix_ready. Simultaneous push and pop leave the count unchanged. pix_valid = FIFO non-empty. Pixel stream has first-word fall-through, so return-to-pix_valid latency is 1 clk.
- pix_sof = pix_valid && (popped==0). pix_eof = pix_valid && (popped==FRAME_WORDS-1). With FRAME_WORDS=1, both are high on the same pixel.
- States:
  - IDLE: start is accepted. Load rd_addr=base_addr and clear counters; busy=1; go to FETCH.
  - FETCH: issue requests under the credit rule. When the last request is accepted, go to DRAIN.
  - DRAIN: wait until popped==FRAME_WORDS.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- start while busy is ignored. start in the same cycle as DONE is ignored.
- Address wrap: rd_addr wraps modulo 2^ADDR_W, with no error.
- Counter widths use $clog2(FRAME_WORDS+1) and $clog2(FIFO_DEPTH+1).
- rd_data_valid outside FETCH/DRAIN, or when outstanding==0, is ignored.

Optional Feature:
- Macro: FRAME_RD_PATT_CHK_EN.
- When defined, the block adds parameter CHK_PATT (default 24'hFFFFFF) and outputs chk_fail (1) and chk_cnt (16).
  - chk_fail is sticky. It sets on any accepted return whose rd_data[23:0] != CHK_PATT, and clears on reset or on accepted start.
  - chk_cnt counts accepted returns in the current frame and saturates at 16'hFFFF.
- When undefined, these ports and this logic do not exist, and the datapath is unchanged.

Test Plan:
- Basic frame: base_addr=0, FRAME_WORDS=5, rd_rdy=1, data returned 3 clks after each request, pix_ready=1 -> rd_addr sequence 0..4, pixels in order, sof on pixel 0, eof on pixel 4, done pulse one cycle after last pop, busy low after.
- Back-pressure: FIFO_DEPTH=4, FRAME_WORDS=16, pix_ready=0 for 40 clks -> at most 4 requests issued, no lost/duplicated data, then all 16 pixels stream after pix_ready=1.
- rd_rdy stall: rd_rdy low for 10 clks mid-frame -> rd_en/rd_addr hold stable, no address skipped.
- Wrap and FRAME_WORDS=1: base_addr=24'hFFFFFE, FRAME_WORDS=3 -> rd_addr FFFFFE, FFFFFF, 000000. Second build with FRAME_WORDS=1 -> single pixel with sof=eof=1.
- Reset mid-operation: reset after 2 of 5 requests, with returns still arriving -> outputs at reset values, late returns ignored, next start runs a clean frame.
- FRAME_RD_PATT_CHK_EN: returns all 24'hFFFFFF -> chk_fail=0, chk_cnt=5. One return 24'h00FFFF -> chk_fail=1 and stays set until next start.
